pc_gen: RTL and testbench
=========================

# pc_gen

Parametrised fetch program-counter generator for the RISC-V core front end; next generation of the single-register PC. Produces the fetch address and a valid/ready request to instruction memory. Resolves prioritised redirects (trap, mret, branch, return-stack pop) and keeps the request address stable while memory back-pressures. Contains a circular return-address stack (RAS) of configurable depth.

## Interface
- XLEN, 32, address width
- RESET_PC, 32'h4000_0000, first fetch address after reset
- FETCH_BYTES, 4, sequential increment per accepted fetch
- RAS_DEPTH, 4, return-stack entries (power of two, >=2)

- i_clk  in  1  clock
- i_reset_n  in  1  reset: asynchronous, active-low
- i_stall  in  1  pipeline stall; blocks sequential advance only
- i_fetch_ready  in  1  instruction memory accepts the request
- o_fetch_valid  out  1  fetch request valid
- o_pc_curr  out  XLEN  fetch address
- o_redirect  out  1  o_pc_curr came from a non-sequential source this cycle
- i_trap, i_trap_vector  in  1, XLEN  trap redirect and target
- i_mret, i_mepc  in  1, XLEN  return-from-trap redirect and target
- i_br_taken, i_br_target  in  1, XLEN  resolved branch/jump redirect and target
- i_ras_push, i_ras_push_addr  in  1, XLEN  push a return address
- i_ras_pop  in  1  pop; redirect to popped address
- o_ras_valid  out  1  RAS non-empty
- o_ras_top  out  XLEN  current top entry (0 when empty)

## Operation
- States: BOOT, RUN, PEND. Reset -> BOOT. BOOT -> RUN unconditionally after one cycle.
- o_fetch_valid = 0 in BOOT, 1 in RUN and PEND.
- Handshake: fire = o_fetch_valid & i_fetch_ready. While valid & !ready, o_pc_curr is held stable.
- Redirect priority: trap > mret > branch > pop. A pop counts as a redirect only if the RAS is non-empty; a pop on an empty RAS is ignored.
- Target alignment: trap target has bits[1:0] cleared; all other targets have bit0 cleared.
- RUN, redirect present, and no pending handshake (!o_fetch_valid | i_fetch_ready):
  - o_pc_curr <= target; o_redirect <= 1.
  - A redirect overrides i_stall.
- RUN, redirect present, and valid & !ready:
  - Capture target in the pending register; go to PEND.
  - o_pc_curr is unchanged.
- RUN, no redirect, fire & !i_stall: o_pc_curr <= o_pc_curr + FETCH_BYTES, modulo 2^XLEN (wraps to 0).
- RUN, otherwise: hold.
- PEND:
  - A new redirect overwrites the pending target; the priority rule applies among same-cycle requests.
  - On i_fetch_ready: o_pc_curr <= pending target (or the same-cycle new redirect); o_redirect <= 1; go to RUN.
- o_redirect is registered. It is 1 only in the cycle the redirected address first appears, 0 otherwise.
- RAS, circular buffer with a count saturating at RAS_DEPTH:
  - Push when full overwrites the oldest entry.
  - Push with pop in the same cycle: redirect to the old top, top replaced by the push address, count unchanged.
  - A pop redirect blocked by a higher-priority redirect still pops.
  - Trap and mret do not alter the RAS.

## Timing
- Reset values:
  - o_pc_curr = RESET_PC
  - o_fetch_valid = 0
  - o_redirect = 0
  - o_ras_valid = 0
  - o_ras_top = 0
  - RAS count = 0; state = BOOT
- First request: RESET_PC with valid = 1 in the second clock edge after reset release.
- Redirect latency: 1 cycle from input to o_pc_curr when not back-pressured; otherwise the first cycle after the edge where ready is seen.
- Reset asserted mid-operation returns all outputs to reset values immediately. A pending redirect is discarded.
- All outputs are registered; there is no combinational input-to-output path.

## Test plan
- Reset release, ready = 1 constant -> pc 0x4000_0000, then 0x4000_0004, 0x4000_0008; valid = 0 for the BOOT cycle only.
- Same-cycle trap (vector 0x8000_0103) and branch (0x4000_0100) -> next pc 0x8000_0100, o_redirect = 1 for one cycle.
- ready = 0 for 3 cycles with branch to 0x4000_0200 in the first cycle -> pc holds; one cycle after ready = 1, pc = 0x4000_0200.
- pc 0xFFFF_FFFC, ready = 1, no stall -> pc 0x0000_0000.
- Push 5 addresses into RAS_DEPTH = 4, then 5 pops -> redirects to addresses 5, 4, 3, 2; 5th pop ignored; o_ras_valid = 0.
- i_stall = 1 with ready = 1 -> pc held; mret during stall to 0x4000_0011 -> pc 0x4000_0010.

Source files
------------

// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// pc_gen : fetch PC generator with prioritised redirects, back-pressure hold
//          and a circular return-address stack.
// Revision: 1.0
// ============================================================================
module pc_gen #(
   parameter int              XLEN        = 32,
   parameter logic [XLEN-1:0] RESET_PC    = 32'h4000_0000,
   parameter int              FETCH_BYTES = 4,
   parameter int              RAS_DEPTH   = 4
) (
   input  logic            i_clk,
   input  logic            i_reset_n,
   input  logic            i_stall,
   input  logic            i_fetch_ready,
   output logic            o_fetch_valid,
   output logic [XLEN-1:0] o_pc_curr,
   output logic            o_redirect,
   input  logic            i_trap,
   input  logic [XLEN-1:0] i_trap_vector,
   input  logic            i_mret,
   input  logic [XLEN-1:0] i_mepc,
   input  logic            i_br_taken,
   input  logic [XLEN-1:0] i_br_target,
   input  logic            i_ras_push,
   input  logic [XLEN-1:0] i_ras_push_addr,
   input  logic            i_ras_pop,
   output logic            o_ras_valid,
   output logic [XLEN-1:0] o_ras_top
);

   localparam int              C_PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int              C_CNT_W = C_PTR_W + 1;
   localparam logic [C_CNT_W-1:0] C_CNT_MAX = C_CNT_W'(RAS_DEPTH);
   localparam logic [XLEN-1:0] C_INC   = XLEN'(FETCH_BYTES);

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_PEND = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [XLEN-1:0]     pc_q, pc_d;
   logic                valid_q, valid_d;
   logic                redir_q, redir_d;
   logic [XLEN-1:0]     pend_q, pend_d;

   logic [XLEN-1:0]     ras_mem_q [RAS_DEPTH];
   logic [C_PTR_W-1:0]  ras_top_q, ras_top_d;
   logic [C_CNT_W-1:0]  ras_cnt_q, ras_cnt_d;
   logic                w_ras_we;
   logic [C_PTR_W-1:0]  w_ras_widx;

   logic                w_ras_nonempty;
   logic                w_pop;
   logic                w_redir_req;
   logic [XLEN-1:0]     w_target;
   logic [XLEN-1:0]     w_ras_top_val;
   logic                w_fire;

   assign w_ras_nonempty = (ras_cnt_q != '0);
   assign w_ras_top_val  = ras_mem_q[ras_top_q];
   // A pop on an empty stack is ignored entirely.
   assign w_pop          = i_ras_pop & w_ras_nonempty;
   assign w_redir_req    = i_trap | i_mret | i_br_taken | w_pop;
   assign w_fire         = valid_q & i_fetch_ready;

   always_comb begin
      w_target = '0;
      if (i_trap) begin
         w_target = {i_trap_vector[XLEN-1:2], 2'b00};
      end else if (i_mret) begin
         w_target = {i_mepc[XLEN-1:1], 1'b0};
      end else if (i_br_taken) begin
         w_target = {i_br_target[XLEN-1:1], 1'b0};
      end else if (w_pop) begin
         w_target = {w_ras_top_val[XLEN-1:1], 1'b0};
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      valid_d = valid_q;
      redir_d = 1'b0;
      pend_d  = pend_q;
      case (state_q)
         ST_BOOT: begin
            state_d = ST_RUN;
            valid_d = 1'b1;
         end
         ST_RUN: begin
            if (w_redir_req) begin
               if (!valid_q || i_fetch_ready) begin
                  pc_d    = w_target;
                  redir_d = 1'b1;
               end else begin
                  pend_d  = w_target;
                  state_d = ST_PEND;
               end
            end else if (w_fire && !i_stall) begin
               pc_d = pc_q + C_INC;
            end
         end
         ST_PEND: begin
            // A same-cycle redirect supersedes the parked target.
            if (i_fetch_ready) begin
               pc_d    = w_redir_req ? w_target : pend_q;
               redir_d = 1'b1;
               state_d = ST_RUN;
            end else if (w_redir_req) begin
               pend_d = w_target;
            end
         end
         default: begin
            state_d = ST_BOOT;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= ST_BOOT;
         pc_q    <= RESET_PC;
         valid_q <= 1'b0;
         redir_q <= 1'b0;
         pend_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
         redir_q <= redir_d;
         pend_q  <= pend_d;
      end
   end

   // Push+pop replaces the top in place; a full push overwrites the oldest slot.
   always_comb begin
      ras_top_d  = ras_top_q;
      ras_cnt_d  = ras_cnt_q;
      w_ras_we   = 1'b0;
      w_ras_widx = ras_top_q;
      if (i_ras_push && w_pop) begin
         w_ras_we   = 1'b1;
         w_ras_widx = ras_top_q;
      end else if (i_ras_push) begin
         w_ras_we   = 1'b1;
         w_ras_widx = ras_top_q + C_PTR_W'(1);
         ras_top_d  = ras_top_q + C_PTR_W'(1);
         if (ras_cnt_q != C_CNT_MAX) begin
            ras_cnt_d = ras_cnt_q + C_CNT_W'(1);
         end
      end else if (w_pop) begin
         ras_top_d = ras_top_q - C_PTR_W'(1);
         ras_cnt_d = ras_cnt_q - C_CNT_W'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         ras_top_q <= '0;
         ras_cnt_q <= '0;
      end else begin
         ras_top_q <= ras_top_d;
         ras_cnt_q <= ras_cnt_d;
      end
   end

   generate
      for (genvar g = 0; g < RAS_DEPTH; g++) begin : g_ras_entry
         always_ff @(posedge i_clk or negedge i_reset_n) begin
            if (!i_reset_n) begin
               ras_mem_q[g] <= '0;
            end else if (w_ras_we && (w_ras_widx == C_PTR_W'(g))) begin
               ras_mem_q[g] <= i_ras_push_addr;
            end
         end
      end
   endgenerate

   assign o_fetch_valid = valid_q;
   assign o_pc_curr     = pc_q;
   assign o_redirect    = redir_q;
   assign o_ras_valid   = w_ras_nonempty;
   assign o_ras_top     = w_ras_nonempty ? w_ras_top_val : '0;

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// ============================================================================
// tb_pc_gen : directed self-checking bench for pc_gen.
// Revision: 1.0
// ============================================================================
module tb_pc_gen;

   logic        clk;
   logic        rst_n;
   logic        stall, ready;
   logic        fetch_valid, redirect, ras_valid;
   logic [31:0] pc_curr, ras_top;
   logic        trap, mret, br, push, pop;
   logic [31:0] trap_vec, mepc, br_tgt, push_addr;

   int checks   = 0;
   int failures = 0;

   pc_gen dut (
      .i_clk          (clk),
      .i_reset_n      (rst_n),
      .i_stall        (stall),
      .i_fetch_ready  (ready),
      .o_fetch_valid  (fetch_valid),
      .o_pc_curr      (pc_curr),
      .o_redirect     (redirect),
      .i_trap         (trap),
      .i_trap_vector  (trap_vec),
      .i_mret         (mret),
      .i_mepc         (mepc),
      .i_br_taken     (br),
      .i_br_target    (br_tgt),
      .i_ras_push     (push),
      .i_ras_push_addr(push_addr),
      .i_ras_pop      (pop),
      .o_ras_valid    (ras_valid),
      .o_ras_top      (ras_top)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      trap = 0; mret = 0; br = 0; push = 0; pop = 0;
   endtask

   initial begin
      rst_n = 0; stall = 0; ready = 1;
      trap_vec = '0; mepc = '0; br_tgt = '0; push_addr = '0;
      clr();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pc",      pc_curr, 32'h4000_0000);
      chk("rst_valid",   {31'b0, fetch_valid}, 32'd0);
      chk("rst_redir",   {31'b0, redirect}, 32'd0);
      chk("rst_rasv",    {31'b0, ras_valid}, 32'd0);
      chk("rst_rastop",  ras_top, 32'd0);
      rst_n = 1;

      step();
      chk("boot_valid",  {31'b0, fetch_valid}, 32'd1);
      chk("first_pc",    pc_curr, 32'h4000_0000);
      step();
      chk("seq_pc1",     pc_curr, 32'h4000_0004);
      step();
      chk("seq_pc2",     pc_curr, 32'h4000_0008);
      chk("seq_redir",   {31'b0, redirect}, 32'd0);

      // trap beats branch, low two bits cleared
      trap = 1; trap_vec = 32'h8000_0103; br = 1; br_tgt = 32'h4000_0100;
      step(); clr();
      chk("trap_pc",     pc_curr, 32'h8000_0100);
      chk("trap_redir",  {31'b0, redirect}, 32'd1);
      step();
      chk("trap_next",   pc_curr, 32'h8000_0104);
      chk("redir_pulse", {31'b0, redirect}, 32'd0);

      // back-pressured branch
      ready = 0; br = 1; br_tgt = 32'h4000_0200;
      step(); clr();
      chk("bp_hold1",    pc_curr, 32'h8000_0104);
      chk("bp_redir0",   {31'b0, redirect}, 32'd0);
      step();
      chk("bp_hold2",    pc_curr, 32'h8000_0104);
      step();
      chk("bp_hold3",    pc_curr, 32'h8000_0104);
      ready = 1;
      step();
      chk("bp_pc",       pc_curr, 32'h4000_0200);
      chk("bp_redir",    {31'b0, redirect}, 32'd1);
      step();
      chk("bp_next",     pc_curr, 32'h4000_0204);

      // wrap-around
      br = 1; br_tgt = 32'hFFFF_FFFC;
      step(); clr();
      chk("wrap_set",    pc_curr, 32'hFFFF_FFFC);
      step();
      chk("wrap_pc",     pc_curr, 32'h0000_0000);

      // stall holds, mret overrides stall
      stall = 1;
      step();
      chk("stall_hold1", pc_curr, 32'h0000_0000);
      step();
      chk("stall_hold2", pc_curr, 32'h0000_0000);
      mret = 1; mepc = 32'h4000_0011;
      step(); clr();
      chk("mret_pc",     pc_curr, 32'h4000_0010);
      chk("mret_redir",  {31'b0, redirect}, 32'd1);
      step();
      chk("stall_hold3", pc_curr, 32'h4000_0010);
      stall = 0;
      step();
      chk("unstall_pc",  pc_curr, 32'h4000_0014);

      // five pushes into a four-entry stack
      for (int i = 0; i < 5; i++) begin
         push = 1; push_addr = 32'h4000_1000 + 32'h10 * i;
         step();
         chk("push_top", ras_top, 32'h4000_1000 + 32'h10 * i);
      end
      clr();
      chk("push_valid",  {31'b0, ras_valid}, 32'd1);
      for (int k = 0; k < 4; k++) begin
         pop = 1;
         step();
         chk("pop_pc",    pc_curr, 32'h4000_1040 - 32'h10 * k);
         chk("pop_redir", {31'b0, redirect}, 32'd1);
         chk("pop_top",   ras_top, (k < 3) ? (32'h4000_1030 - 32'h10 * k) : 32'd0);
      end
      step(); clr();
      chk("pop5_pc",     pc_curr, 32'h4000_1014);
      chk("pop5_redir",  {31'b0, redirect}, 32'd0);
      chk("pop5_valid",  {31'b0, ras_valid}, 32'd0);

      // push and pop together
      push = 1; push_addr = 32'h4000_2000;
      step();
      push = 1; push_addr = 32'h4000_3000; pop = 1;
      step(); clr();
      chk("pp_pc",       pc_curr, 32'h4000_2000);
      chk("pp_top",      ras_top, 32'h4000_3000);
      pop = 1;
      step(); clr();
      chk("pp_pop_pc",   pc_curr, 32'h4000_3000);
      chk("pp_empty",    {31'b0, ras_valid}, 32'd0);

      // pop shadowed by branch still consumes the entry
      push = 1; push_addr = 32'h4000_4000;
      step(); clr();
      br = 1; br_tgt = 32'h4000_5000; pop = 1;
      step(); clr();
      chk("shadow_pc",   pc_curr, 32'h4000_5000);
      chk("shadow_rasv", {31'b0, ras_valid}, 32'd0);

      // trap leaves the stack alone
      push = 1; push_addr = 32'h4000_B000;
      step(); clr();
      trap = 1; trap_vec = 32'h8000_0000;
      step(); clr();
      chk("trap2_pc",    pc_curr, 32'h8000_0000);
      chk("trap2_top",   ras_top, 32'h4000_B000);

      // mret beats branch
      mret = 1; mepc = 32'h4000_6000; br = 1; br_tgt = 32'h4000_7000;
      step(); clr();
      chk("prio_mret",   pc_curr, 32'h4000_6000);

      // pending target overwritten while back-pressured
      ready = 0; br = 1; br_tgt = 32'h4000_8000;
      step();
      br_tgt = 32'h4000_9000;
      step(); clr();
      ready = 1;
      step();
      chk("pend_ovr",    pc_curr, 32'h4000_9000);

      // asynchronous reset discards a pending redirect
      ready = 0; br = 1; br_tgt = 32'h4000_A000;
      step(); clr();
      rst_n = 0;
      #1;
      chk("arst_pc",     pc_curr, 32'h4000_0000);
      chk("arst_valid",  {31'b0, fetch_valid}, 32'd0);
      chk("arst_rasv",   {31'b0, ras_valid}, 32'd0);
      ready = 1;
      step();
      rst_n = 1;
      step();
      chk("rerun_pc0",   pc_curr, 32'h4000_0000);
      step();
      chk("rerun_pc1",   pc_curr, 32'h4000_0004);
      chk("rerun_redir", {31'b0, redirect}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
